// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, TX/RX state enumerations and parity helpers.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  // Mode 11 behaves exactly like PAR_NONE.
  function automatic logic par_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  function automatic logic par_bit(input logic [7:0] d, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional-N oversample tick: free-running phase accumulator, one tick per wrap.
module uart_baud_tick #(
  parameter int unsigned SYS_CLK_RATE = 50000000,
  parameter int unsigned OVERSAMPLE   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [28:0] baud_i,
  output logic        tick_o
);

  logic [31:0] acc_q, acc_d;
  logic [32:0] inc, sum;
  logic        tick_q, tick_d;

  assign inc = 33'(baud_i) * 33'(OVERSAMPLE);
  assign sum = {1'b0, acc_q} + inc;

  always_comb begin
    tick_d = 1'b0;
    acc_d  = sum[31:0];
    if (sum >= 33'(SYS_CLK_RATE)) begin
      tick_d = 1'b1;
      acc_d  = 32'(sum - 33'(SYS_CLK_RATE));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: shared oversample tick, TX framer and majority-voting RX deframer.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned SYS_CLK_RATE = 50000000,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DEFAULT_BAUD = 9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [28:0] baud_rate,
  input  logic [1:0]  parity_mode,
  input  logic        stop_bits,
  input  logic        wr_i,
  input  logic [7:0]  dat_i,
  output logic        tx_busy,
  output logic        tx,
  input  logic        rx,
  output logic        rx_busy,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_parity_err,
  output logic        rx_frame_err
);

  localparam int unsigned PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PH_MIDM = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_MID  = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_MIDP = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);
  localparam logic [7:0]    DMASK    = 8'((1 << DATA_BITS) - 1);

  logic [28:0] baud_q;
  logic        tick;

  // Baud only moves while both directions are idle, so no frame sees a rate change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 baud_q <= 29'(DEFAULT_BAUD);
    else if (!tx_busy && !rx_busy) baud_q <= baud_rate;
  end

  uart_baud_tick #(.SYS_CLK_RATE(SYS_CLK_RATE), .OVERSAMPLE(OVERSAMPLE)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .baud_i (baud_q),
    .tick_o (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_e     tst_q, tst_d;
  logic [PW-1:0] tph_q, tph_d;
  logic [2:0]    tcnt_q, tcnt_d;
  logic [7:0]    tsh_q, tsh_d;
  logic          tpar_q, tpar_d, tstop2_q, tstop2_d, tbusy_q, tbusy_d;
  logic [1:0]    tmode_q, tmode_d;

  always_comb begin
    tst_d = tst_q; tph_d = tph_q; tcnt_d = tcnt_q; tsh_d = tsh_q;
    tpar_d = tpar_q; tstop2_d = tstop2_q; tbusy_d = tbusy_q; tmode_d = tmode_q;
    if (tst_q == TX_IDLE) begin
      // busy while still IDLE means a frame is accepted and waits for tick alignment
      if (!tbusy_q) begin
        if (wr_i) begin
          tsh_d    = dat_i & DMASK;
          tpar_d   = par_bit(dat_i & DMASK, parity_mode);
          tmode_d  = parity_mode;
          tstop2_d = stop_bits;
          tbusy_d  = 1'b1;
        end
      end else if (tick) begin
        tst_d = TX_START;
        tph_d = '0;
      end
    end else if (tick) begin
      if (tph_q != PH_LAST) begin
        tph_d = tph_q + 1'b1;
      end else begin
        tph_d = '0;
        case (tst_q)
          TX_START: begin tst_d = TX_DATA; tcnt_d = '0; end
          TX_DATA: begin
            if (tcnt_q == BIT_LAST) tst_d = par_on(tmode_q) ? TX_PARITY : TX_STOP1;
            else begin tcnt_d = tcnt_q + 1'b1; tsh_d = tsh_q >> 1; end
          end
          TX_PARITY: tst_d = TX_STOP1;
          TX_STOP1: begin
            if (tstop2_q) tst_d = TX_STOP2;
            else begin tst_d = TX_IDLE; tbusy_d = 1'b0; end
          end
          default: begin tst_d = TX_IDLE; tbusy_d = 1'b0; end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tst_q <= TX_IDLE; tph_q <= '0; tcnt_q <= '0; tsh_q <= '0;
      tpar_q <= 1'b0; tstop2_q <= 1'b0; tbusy_q <= 1'b0; tmode_q <= PAR_NONE;
    end else begin
      tst_q <= tst_d; tph_q <= tph_d; tcnt_q <= tcnt_d; tsh_q <= tsh_d;
      tpar_q <= tpar_d; tstop2_q <= tstop2_d; tbusy_q <= tbusy_d; tmode_q <= tmode_d;
    end
  end

  always_comb begin
    tx = 1'b1;
    case (tst_q)
      TX_START:  tx = 1'b0;
      TX_DATA:   tx = tsh_q[0];
      TX_PARITY: tx = tpar_q;
      default:   tx = 1'b1;
    endcase
  end

  assign tx_busy = tbusy_q;

  // ---------------- receiver ----------------
  rx_state_e            rst_q, rst_d;
  logic [1:0]           rsync_q;
  logic [PW-1:0]        rph_q, rph_d;
  logic [2:0]           rcnt_q, rcnt_d;
  logic [DATA_BITS-1:0] rsh_q, rsh_d;
  logic [1:0]           vote_q, vote_d, rmode_q, rmode_d;
  logic                 rpar_q, rpar_d, rval_q, rval_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [7:0]           rdat_q, rdat_d;
  logic                 rxs, maj;

  assign rxs = rsync_q[1];
  // vote_q holds the mid-1 and mid samples; the current rxs is the mid+1 sample
  assign maj = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs) | (vote_q[1] & rxs);

  always_comb begin
    rst_d = rst_q; rph_d = rph_q; rcnt_d = rcnt_q; rsh_d = rsh_q; vote_d = vote_q;
    rmode_d = rmode_q; rpar_d = rpar_q; rval_d = 1'b0;
    perr_d = perr_q; ferr_d = ferr_q; rdat_d = rdat_q;
    case (rst_q)
      RX_IDLE: if (!rxs) begin rst_d = RX_START; rph_d = '0; rmode_d = parity_mode; end
      RX_WAIT_HIGH: if (rxs) rst_d = RX_IDLE;
      default: if (tick) begin
        rph_d = rph_q + 1'b1;
        if (rph_q == PH_MIDM) vote_d[0] = rxs;
        if (rph_q == PH_MID)  vote_d[1] = rxs;
        case (rst_q)
          RX_START: begin
            if (rph_q == PH_MID && rxs) rst_d = RX_IDLE;
            else if (rph_q == PH_LAST) begin rst_d = RX_DATA; rcnt_d = '0; end
          end
          RX_DATA: begin
            if (rph_q == PH_MIDP) rsh_d = {maj, rsh_q[DATA_BITS-1:1]};
            if (rph_q == PH_LAST) begin
              if (rcnt_q == BIT_LAST) rst_d = par_on(rmode_q) ? RX_PARITY : RX_STOP;
              else rcnt_d = rcnt_q + 1'b1;
            end
          end
          RX_PARITY: begin
            if (rph_q == PH_MIDP) rpar_d = maj;
            if (rph_q == PH_LAST) rst_d = RX_STOP;
          end
          RX_STOP: if (rph_q == PH_MIDP) begin
            rval_d = 1'b1;
            rdat_d = 8'(rsh_q);
            perr_d = par_on(rmode_q) && (rpar_q != par_bit(8'(rsh_q), rmode_q));
            ferr_d = ~maj;
            rst_d  = maj ? RX_IDLE : RX_WAIT_HIGH;
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_q <= RX_IDLE; rsync_q <= 2'b11; rph_q <= '0; rcnt_q <= '0; rsh_q <= '0;
      vote_q <= '0; rmode_q <= PAR_NONE; rpar_q <= 1'b0; rval_q <= 1'b0;
      perr_q <= 1'b0; ferr_q <= 1'b0; rdat_q <= '0;
    end else begin
      rst_q <= rst_d; rsync_q <= {rsync_q[0], rx}; rph_q <= rph_d; rcnt_q <= rcnt_d;
      rsh_q <= rsh_d; vote_q <= vote_d; rmode_q <= rmode_d; rpar_q <= rpar_d;
      rval_q <= rval_d; perr_q <= perr_d; ferr_q <= ferr_d; rdat_q <= rdat_d;
    end
  end

  assign rx_busy       = (rst_q == RX_START) || (rst_q == RX_DATA) ||
                         (rst_q == RX_PARITY) || (rst_q == RX_STOP);
  assign rx_valid      = rval_q;
  assign rx_data       = rdat_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;

endmodule
